// File: rtl/mux8_scan_ctrl_pkg.sv
// Shared definitions for the 8:1 mux scan controller.
// Optional feature macro: MUX8_PARITY_EN (adds the PAR state and parity bit).
package mux8_scan_ctrl_pkg;

  localparam int unsigned SCAN_LEN = 8;
  localparam int unsigned SEL_W    = 3;

  typedef logic [SEL_W-1:0] sel_t;

`ifdef MUX8_PARITY_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  // Index scanned first in a word.
  function automatic sel_t first_sel(input bit msb_first);
    return msb_first ? sel_t'(SCAN_LEN - 1) : sel_t'(0);
  endfunction

  // Index scanned last in a word.
  function automatic sel_t last_sel(input bit msb_first);
    return msb_first ? sel_t'(0) : sel_t'(SCAN_LEN - 1);
  endfunction

endpackage

// File: rtl/mux8_scan_ctrl_sel_counter3.sv
// 3-bit select counter: sync reset value, sync load, enable, up/down.
module sel_counter3
  import mux8_scan_ctrl_pkg::*;
#(
  parameter sel_t RST_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic up,
  input  logic ld,
  input  sel_t ld_val,
  output sel_t q
);

  // Load has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= up ? q + sel_t'(1) : q - sel_t'(1);
    end
  end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Serialises an 8-bit word through an external 8:1 mux by stepping its select.
// Optional feature macro: MUX8_PARITY_EN (appends an even-parity bit per word).
module mux8_scan_ctrl
  import mux8_scan_ctrl_pkg::*;
#(
  parameter bit         MSB_FIRST = 1'b0,
  parameter logic [2:0] IDLE_SEL  = 3'b000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SCAN_LEN-1:0] din,
  input  logic                hold,
  input  logic                mux_o,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                e,
  output logic                f,
  output logic                g,
  output logic                h,
  output logic                s1,
  output logic                s2,
  output logic                s3,
  output logic                ready,
  output logic                sout,
  output logic                sout_valid,
  output logic                done
);

  state_t              state, next_state;
  logic [SCAN_LEN-1:0] data_q, data_d;
  sel_t                sel;
  sel_t                cnt_ld_val;
  logic                cnt_en, cnt_ld;
  logic                sout_d, sout_valid_d, done_d, ready_d;
  logic                last;

  assign last = (sel == last_sel(MSB_FIRST));

  assign {h, g, f, e, d, c, b, a} = data_q;
  assign {s1, s2, s3}             = sel;

  sel_counter3 #(
    .RST_VAL (sel_t'(IDLE_SEL))
  ) u_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (cnt_en),
    .up     (!MSB_FIRST),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .q      (sel)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; hold freezes SCAN/PAR, the counter never wraps inside a word.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (load) next_state = SCAN;
`ifdef MUX8_PARITY_EN
      SCAN: if (!hold && last) next_state = PAR;
      PAR:  if (!hold) next_state = DONE;
`else
      SCAN: if (!hold && last) next_state = DONE;
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath control for the next cycle.
  always_comb begin
    data_d       = data_q;
    cnt_en       = 1'b0;
    cnt_ld       = 1'b0;
    cnt_ld_val   = sel_t'(IDLE_SEL);
    sout_d       = sout;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
    ready_d      = (next_state == IDLE);
    case (state)
      IDLE: begin
        if (load) begin
          data_d     = din;
          cnt_ld     = 1'b1;
          cnt_ld_val = first_sel(MSB_FIRST);
        end
      end
      SCAN: begin
        if (!hold) begin
          sout_d       = mux_o;
          sout_valid_d = 1'b1;
          cnt_en       = !last;
        end
      end
`ifdef MUX8_PARITY_EN
      PAR: begin
        if (!hold) begin
          sout_d       = ^data_q;
          sout_valid_d = 1'b1;
        end
      end
`endif
      DONE: begin
        done_d     = 1'b1;
        cnt_ld     = 1'b1;
        cnt_ld_val = sel_t'(IDLE_SEL);
      end
      default: ;
    endcase
  end

  // Registered outputs and latched word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q     <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
      ready      <= 1'b1;
    end else begin
      data_q     <= data_d;
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      done       <= done_d;
      ready      <= ready_d;
    end
  end

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl; honours MUX8_PARITY_EN when defined.
module tb_mux8_scan_ctrl;
  import mux8_scan_ctrl_pkg::*;

`ifdef MUX8_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  logic clk = 1'b0;
  logic rst_n, hold, load0, load1;
  logic [7:0] din;

  logic a0, b0, c0, d0, e0, f0, g0, h0, s10, s20, s30, ready0, sout0, sv0, done0, mux_o0;
  logic a1, b1, c1, d1, e1, f1, g1, h1, s11, s21, s31, ready1, sout1, sv1, done1, mux_o1;

  always #5 clk = ~clk;

  // Existing 8x1 dataflow mux closing the loop for each instance.
  assign mux_o0 = s10 ? (s20 ? (s30 ? h0 : g0) : (s30 ? f0 : e0))
                      : (s20 ? (s30 ? d0 : c0) : (s30 ? b0 : a0));
  assign mux_o1 = s11 ? (s21 ? (s31 ? h1 : g1) : (s31 ? f1 : e1))
                      : (s21 ? (s31 ? d1 : c1) : (s31 ? b1 : a1));

  mux8_scan_ctrl #(.MSB_FIRST(1'b0), .IDLE_SEL(3'b000)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load0), .din(din), .hold(hold), .mux_o(mux_o0),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .h(h0),
    .s1(s10), .s2(s20), .s3(s30), .ready(ready0), .sout(sout0),
    .sout_valid(sv0), .done(done0)
  );

  mux8_scan_ctrl #(.MSB_FIRST(1'b1), .IDLE_SEL(3'b101)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .din(din), .hold(hold), .mux_o(mux_o1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .s1(s11), .s2(s21), .s3(s31), .ready(ready1), .sout(sout1),
    .sout_valid(sv1), .done(done1)
  );

  // View of whichever instance the current vector targets.
  bit         cur;
  logic [2:0] sel_v, idle_v;
  logic [7:0] data_v;
  logic       ready_v, sout_v, sv_v, done_v;
  assign sel_v   = cur ? {s11, s21, s31} : {s10, s20, s30};
  assign idle_v  = cur ? 3'b101 : 3'b000;
  assign data_v  = cur ? {h1, g1, f1, e1, d1, c1, b1, a1} : {h0, g0, f0, e0, d0, c0, b0, a0};
  assign ready_v = cur ? ready1 : ready0;
  assign sout_v  = cur ? sout1 : sout0;
  assign sv_v    = cur ? sv1 : sv0;
  assign done_v  = cur ? done1 : done0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // exp_bits[j] is the hand-computed value of strobe j; exp_par is the 9th strobe.
  typedef struct {
    logic [7:0] din;
    bit         msb;
    int         hold_at;
    int         hold_len;
    int         busy_at;
    logic [7:0] exp_bits;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int         strobes, done_cnt, done_at, exp_n, exp_done;
    logic [2:0] frozen;
    exp_n    = 8 + PX;
    exp_done = 10 + v.hold_len + PX;
    strobes  = 0;
    done_cnt = 0;
    done_at  = -1;
    frozen   = '0;
    cur      = v.msb;
    @(negedge clk);
    chk("ready_before_load", 32'(ready_v), 32'd1);
    din = v.din;
    if (v.msb) load1 = 1'b1; else load0 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      load0 = 1'b0;
      load1 = 1'b0;
      hold  = (v.hold_len > 0) && (k >= v.hold_at) && (k < v.hold_at + v.hold_len);
      if (k == 1) begin
        chk("ready_after_load", 32'(ready_v), 32'd0);
        chk("latched_word", 32'(data_v), 32'(v.din));
      end
      if (v.busy_at == k) begin
        din = 8'hFF;
        if (v.msb) load1 = 1'b1; else load0 = 1'b1;
      end
      if (v.hold_len == 0 && k <= 8)
        chk("sel_order", 32'(sel_v), v.msb ? 32'(8 - k) : 32'(k - 1));
      if (v.hold_len > 0 && k == v.hold_at) frozen = sel_v;
      if (v.hold_len > 0 && k > v.hold_at && k <= v.hold_at + v.hold_len)
        chk("sel_frozen", 32'(sel_v), 32'(frozen));
      if (sv_v) begin
        if (strobes < 8)
          chk("sout_bit", 32'(sout_v), 32'(v.exp_bits[strobes]));
        else if (strobes < exp_n)
          chk("sout_parity", 32'(sout_v), 32'(v.exp_par));
        strobes++;
      end
      if (done_v) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == exp_done) begin
        chk("sel_idle_after_done", 32'(sel_v), 32'(idle_v));
        chk("ready_at_done", 32'(ready_v), 32'd1);
      end
    end
    chk("strobe_count", 32'(strobes), 32'(exp_n));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_cycle", 32'(done_at), 32'(exp_done));
    chk("word_held", 32'(data_v), 32'(v.din));
  endtask

  initial begin
    // din, msb, hold_at, hold_len, busy_at, exp_bits, exp_par
    vecs[0] = '{8'hA5, 1'b0, 0, 0, 0, 8'hA5, 1'b0};  // 1,0,1,0,0,1,0,1
    vecs[1] = '{8'h01, 1'b1, 0, 0, 0, 8'h80, 1'b1};  // seven 0s then 1
    vecs[2] = '{8'hF0, 1'b0, 5, 3, 0, 8'hF0, 1'b0};  // stall after 4th strobe
    vecs[3] = '{8'hA5, 1'b0, 0, 0, 3, 8'hA5, 1'b0};  // busy load ignored
    vecs[4] = '{8'h07, 1'b0, 0, 0, 0, 8'h07, 1'b1};  // 1,1,1,0,0,0,0,0 | par 1
    vecs[5] = '{8'h03, 1'b0, 0, 0, 0, 8'h03, 1'b0};  // 1,1,0,0,0,0,0,0 | par 0

    rst_n = 1'b0; hold = 1'b0; load0 = 1'b0; load1 = 1'b0; din = 8'h00; cur = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur = (i == 1);
      #1;
      chk("rst_ready", 32'(ready_v), 32'd1);
      chk("rst_word", 32'(data_v), 32'd0);
      chk("rst_sel", 32'(sel_v), 32'(idle_v));
      chk("rst_sout", 32'({sout_v, sv_v, done_v}), 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Extra MSB-first word: C5 scanned 7->0 gives 1,1,0,0,0,1,0,1.
    run_vec('{8'hC5, 1'b1, 0, 0, 0, 8'hA3, 1'b0});

    // Reset during SCAN after the 3rd strobe aborts the word without done.
    begin
      int strobes, dones;
      strobes = 0;
      dones   = 0;
      cur     = 1'b0;
      @(negedge clk);
      din   = 8'h5A;
      load0 = 1'b1;
      for (int k = 1; k <= 15; k++) begin
        @(negedge clk);
        load0 = 1'b0;
        if (sv_v) strobes++;
        if (done_v) dones++;
        if (k == 4) begin
          chk("abort_strobes_before", 32'(strobes), 32'd3);
          rst_n = 1'b0;
        end
        if (k == 5) begin
          rst_n = 1'b1;
          chk("abort_ready", 32'(ready_v), 32'd1);
          chk("abort_word", 32'(data_v), 32'd0);
          chk("abort_sel", 32'(sel_v), 32'(idle_v));
          chk("abort_valid", 32'(sv_v), 32'd0);
        end
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_strobes_total", 32'(strobes), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
